// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer and its buffer.
//   XLEN/ILEN : address and instruction widths
//   PC_STEP   : sequential fetch increment
//   fetch_state_e : sequencer state (RUN fetching, HALT after a fetch fault)
//   fetch_entry_t : one buffered instruction together with its PC
package fetch_pkg;
    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 64'd4;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO holding fetched instructions until decode takes them.
//   clk, rst         : clock, async active-high reset
//   push_i / data_i  : enqueue an entry (accepted when not full, or full with a pop)
//   pop_i            : dequeue the head (ignored when empty)
//   flush_i          : drop all entries and zero the pointers; wins over push
//   data_o           : head entry (don't-care while empty)
//   full_o, empty_o  : occupancy flags
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t data_i,
    output fetch_entry_t data_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t    mem_q [DEPTH];
    logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]   count_q;
    logic            do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = mem_q[rd_ptr_q];

    // Storage needs no reset: contents are only observed behind count_q.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i)
            mem_q[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // DEPTH is a power of two, so pointer wrap is free.
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/fetch_sequencer.sv
// Owns the fetch PC, issues one fetch per cycle, buffers results for decode,
// applies execute redirects and halts on an invalid fetch address.
//   clk, reset                 : clock, async active-high reset
//   fetch_pc / fetch_instr     : PC to the fetch stage and its returned word
//   fetch_inv                  : fetch stage flags fetch_pc as invalid
//   redirect_valid/redirect_pc : control-flow change from execute
//   dec_valid/dec_instr/dec_pc : buffer head towards decode
//   dec_ready                  : decode accepts the head
//   fault / fault_pc           : fetch halted, and the PC that faulted
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int          BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] fetch_pc,
    input  logic [ILEN-1:0] fetch_instr,
    input  logic            fetch_inv,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            dec_valid,
    output logic [ILEN-1:0] dec_instr,
    output logic [XLEN-1:0] dec_pc,
    input  logic            dec_ready,
    output logic            fault,
    output logic [XLEN-1:0] fault_pc
);
    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            fault_q, fault_d;
    logic [XLEN-1:0] fault_pc_q, fault_pc_d;

    logic            buf_full, buf_empty;
    logic            pop, fetch_en, push;
    fetch_entry_t    wr_entry, head;

    assign pop      = dec_valid & dec_ready;
    // A full buffer still fetches when the head leaves this cycle.
    assign fetch_en = (state_q == RUN) & (~buf_full | pop) & ~redirect_valid;
    assign push     = fetch_en & ~fetch_inv;

    assign wr_entry.instr = fetch_instr;
    assign wr_entry.pc    = pc_q;

    fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk     (clk),
        .rst     (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .data_i  (wr_entry),
        .data_o  (head),
        .full_o  (buf_full),
        .empty_o (buf_empty)
    );

    assign fetch_pc  = pc_q;
    assign dec_valid = ~buf_empty;
    assign dec_instr = head.instr;
    assign dec_pc    = head.pc;
    assign fault     = fault_q;
    assign fault_pc  = fault_pc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        if (redirect_valid) begin
            // Redirect overrides everything, including a latched fault.
            pc_d    = redirect_pc;
            state_d = RUN;
            fault_d = 1'b0;
        end else if (fetch_en) begin
            if (fetch_inv) begin
                state_d    = HALT;
                fault_d    = 1'b1;
                fault_pc_d = pc_q;
            end else begin
                pc_d = pc_q + PC_STEP;
            end
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] fetch_pc;
    logic [31:0] fetch_instr;
    logic        fetch_inv;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [63:0] dec_pc;
    logic        dec_ready;
    logic        fault;
    logic [63:0] fault_pc;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Instruction memory model: valid for aligned PCs below 0x1000.
    function automatic logic [31:0] instr_at(input logic [63:0] pc);
        case (pc)
            64'h0:   return 32'h00550533;
            64'h4:   return 32'h40b50533;
            64'h8:   return 32'h00c57533;
            default: return pc[31:0] ^ 32'hDEAD0000;
        endcase
    endfunction

    assign fetch_instr = instr_at(fetch_pc);
    assign fetch_inv   = (fetch_pc[1:0] != 2'b00) || (fetch_pc >= 64'h1000);

    fetch_sequencer #(.RESET_PC(64'h0), .BUF_DEPTH(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_pc       (fetch_pc),
        .fetch_instr    (fetch_instr),
        .fetch_inv      (fetch_inv),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .dec_ready      (dec_ready),
        .fault          (fault),
        .fault_pc       (fault_pc)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic rdy);
        @(negedge clk);
        reset = 1'b1; dec_ready = rdy; redirect_valid = 1'b0; redirect_pc = '0;
        step(1);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; dec_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        // Reset state
        step(1);
        chk("rst_dec_valid", 64'(dec_valid), 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);
        chk("rst_fault_pc", fault_pc, 64'h0);
        chk("rst_fetch_pc", fetch_pc, 64'h0);
        reset = 1'b0;

        // Streaming from reset, decode always ready
        step(1);
        chk("s0_valid", 64'(dec_valid), 64'd1);
        chk("s0_pc", dec_pc, 64'h0);
        chk("s0_instr", 64'(dec_instr), 64'h00550533);
        chk("s0_fetch_pc", fetch_pc, 64'h4);
        step(1);
        chk("s1_pc", dec_pc, 64'h4);
        chk("s1_instr", 64'(dec_instr), 64'h40b50533);
        step(1);
        chk("s2_pc", dec_pc, 64'h8);
        chk("s2_instr", 64'(dec_instr), 64'h00c57533);
        chk("s2_fault", 64'(fault), 64'd0);

        // Backpressure: buffer saturates, PC stops at 0x8
        do_reset(1'b0);
        step(5);
        chk("bp_fetch_pc", fetch_pc, 64'h8);
        chk("bp_head_pc", dec_pc, 64'h0);
        chk("bp_head_instr", 64'(dec_instr), 64'h00550533);
        dec_ready = 1'b1;
        chk("bp_d0", dec_pc, 64'h0);
        step(1);
        chk("bp_d1", dec_pc, 64'h4);
        step(1);
        chk("bp_d2", dec_pc, 64'h8);
        step(1);
        chk("bp_d3", dec_pc, 64'hC);

        // Redirect while buffer holds 0x4 and 0x8
        do_reset(1'b0);
        step(2);                       // full with 0x0, 0x4
        dec_ready = 1'b1;
        step(1);                       // pop 0x0, push 0x8
        chk("rd_pre_head", dec_pc, 64'h4);
        dec_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h100;
        step(1);
        chk("rd_flush_valid", 64'(dec_valid), 64'd0);
        chk("rd_fetch_pc", fetch_pc, 64'h100);
        redirect_valid = 1'b0; dec_ready = 1'b1;
        step(1);
        chk("rd_t0_valid", 64'(dec_valid), 64'd1);
        chk("rd_t0_pc", dec_pc, 64'h100);
        step(1);
        chk("rd_t1_pc", dec_pc, 64'h104);

        // Misaligned redirect target faults on the next cycle
        dec_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h102;
        step(1);
        chk("mis_fault_early", 64'(fault), 64'd0);
        redirect_valid = 1'b0;
        step(1);
        chk("mis_fault", 64'(fault), 64'd1);
        chk("mis_fault_pc", fault_pc, 64'h102);
        chk("mis_valid", 64'(dec_valid), 64'd0);
        step(3);
        chk("halt_fetch_pc", fetch_pc, 64'h102);
        chk("halt_fault_hold", 64'(fault), 64'd1);

        // Leave HALT by redirect to 0x0
        dec_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h0;
        step(1);
        chk("rx_fault", 64'(fault), 64'd0);
        chk("rx_fetch_pc", fetch_pc, 64'h0);
        redirect_valid = 1'b0;
        step(1);
        chk("rx_pc", dec_pc, 64'h0);
        chk("rx_instr", 64'(dec_instr), 64'h00550533);

        // Run off the end of memory with a buffered entry still draining
        dec_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'hFF8;
        step(1);
        redirect_valid = 1'b0;
        step(3);                       // FF8, FFC buffered; stalled at 0x1000
        chk("end_fetch_pc", fetch_pc, 64'h1000);
        chk("end_nofault", 64'(fault), 64'd0);
        chk("end_h0", dec_pc, 64'hFF8);
        dec_ready = 1'b1;
        step(1);
        chk("end_fault", 64'(fault), 64'd1);
        chk("end_fault_pc", fault_pc, 64'h1000);
        chk("end_h1_valid", 64'(dec_valid), 64'd1);
        chk("end_h1", dec_pc, 64'hFFC);
        chk("end_h1_instr", 64'(dec_instr), 64'(32'h00000FFC ^ 32'hDEAD0000));
        step(1);
        chk("end_drained", 64'(dec_valid), 64'd0);

        // Async reset in the middle of a full-buffer stall
        dec_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h0;
        step(1);
        redirect_valid = 1'b0;
        step(4);
        chk("mr_stall_pc", fetch_pc, 64'h8);
        #2 reset = 1'b1;
        #1;
        chk("mr_valid", 64'(dec_valid), 64'd0);
        chk("mr_fetch_pc", fetch_pc, 64'h0);
        chk("mr_fault", 64'(fault), 64'd0);
        chk("mr_fault_pc", fault_pc, 64'h0);
        step(1);
        reset = 1'b0; dec_ready = 1'b1;
        step(1);
        chk("mr_resume_pc", dec_pc, 64'h0);
        step(1);
        chk("mr_resume_pc1", dec_pc, 64'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
